seq_mult4_shift_add: RTL
========================

// Module: seq_mult4_shift_add
// PURPOSE
//   Sequential 4x4 unsigned shift-and-add multiplier built around one rca_dataflow
//   instance. Upstream control stage: it sequences multiplicand/partial-product
//   operands into the 4-bit adder and consumes its s/cout each cycle. It produces an
//   8-bit product after four add/shift iterations, with a start/busy/done handshake.
// PARAMETERS
//   WIDTH  4  operand width; fixed at 4 to match rca_dataflow; other values unsupported
// PORTS
//   clk      in   1  single clock, rising-edge
//   rst_n    in   1  asynchronous, active-low reset
//   start    in   1  request; sampled only in IDLE or DONE
//   a        in   4  multiplicand, captured on accepted start
//   b        in   4  multiplier, captured on accepted start
//   busy     out  1  high while in RUN
//   done     out  1  one-cycle pulse: product valid
//   product  out  8  unsigned a*b; held until the next completed operation
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; busy=0, done=0, product=8'h00; internal
//     mcand, acc_hi, acc_lo, carry, count all cleared. Effective immediately, mid-op too.
//   Datapath regs: mcand[3:0], acc_hi[3:0], acc_lo[3:0] (holds multiplier, shifts
//     out LSB-first), count[1:0]. Adder: a=acc_hi, b=mcand, cin=1'b0 (tied).
//   FSM states IDLE, RUN, DONE:
//     IDLE: start=1 -> mcand<=a, acc_lo<=b, acc_hi<=0, count<=0, go RUN.
//     RUN (exactly 4 cycles): if acc_lo[0]=1, {c,hs}={cout,s}, else {c,hs}={0,acc_hi};
//       then {acc_hi,acc_lo} <= {c,hs,acc_lo[3:1]} (5+4 bits shifted right by 1).
//       count increments; on count==3 iteration: product<={next acc_hi,next acc_lo},
//       go DONE.
//     DONE (1 cycle): done=1. start=1 here is accepted exactly as in IDLE (captures
//       a/b, go RUN) -> back-to-back ops; else go IDLE.
//   busy=1 iff state==RUN. done=1 iff state==DONE. done and busy never both high.
//   Latency: start accepted at edge k -> RUN edges k+1..k+4 -> done high during cycle
//     after edge k+4 (product updated at edge k+4). Issue rate 1 op / 5 cycles.
//   start while busy: ignored, no effect on operands or count; not queued.
//   a/b changes after acceptance: no effect on current operation.
//   Width rule: 4x4 unsigned fits 8 bits; no overflow. Max 15*15=225 (8'hE1).
//   product changes only at the final RUN edge or reset; stable otherwise.
// TESTING
//   1 reset, start a=15,b=15 -> busy 4 cycles, done 1 pulse, product=8'hE1 (225).
//   2 a=0,b=9 then a=9,b=0 -> product=8'h00 both; a=1,b=9 -> 8'h09; a=12,b=5 -> 8'h3C.
//   3 start a=7,b=3; assert start with a=15,b=15 during RUN -> product=8'h15 (21),
//     no second done; then start held in DONE with a=2,b=3 -> busy next cycle, product=6.
//   4 start a=13,b=11, drop rst_n after 2 RUN cycles -> busy/done/product=0 at once,
//     IDLE after release; new op a=3,b=4 -> product=8'h0C.
//   5 exhaustive a,b in 0..15 back-to-back via DONE-start -> every product=a*b,
//     exactly 5 cycles between done pulses, busy never overlaps done.

Source files
------------

// File: rtl/seq_mult4_shift_add.sv
// ---------------------------------------------------------------------------
// seq_mult4_shift_add
//   Sequential 4x4 unsigned shift-and-add multiplier. One 4-bit ripple-carry
//   adder (rca_dataflow) is reused over four iterations. Each iteration
//   conditionally adds the multiplicand into the upper half of the
//   accumulator, then shifts the 9-bit {carry, acc_hi, acc_lo} right by one.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  operation request, honoured only in IDLE or DONE
//   a        in   4  multiplicand, captured when start is accepted
//   b        in   4  multiplier, captured when start is accepted
//   busy     out  1  high while the four iterations are running
//   done     out  1  one-cycle pulse, product valid
//   product  out  8  a*b of the last completed operation
// ---------------------------------------------------------------------------

// rca_dataflow: 4-bit ripple-carry adder described as a dataflow carry chain.
//   a, b   in   4  addends
//   cin    in   1  carry in
//   s      out  4  sum
//   cout   out  1  carry out
module rca_dataflow (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

module seq_mult4_shift_add #(
    parameter int WIDTH = 4  // fixed by the 4-bit adder; other values unsupported
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // multiplier bits, consumed LSB-first
    logic [1:0]         count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   add_s;
    logic               add_cout;
    logic               step_c;               // carry that enters acc_hi MSB on shift
    logic [WIDTH-1:0]   step_hs;              // upper half before the shift

    rca_dataflow u_adder (
        .a    (acc_hi_q),
        .b    (mcand_q),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves a signal unassigned (which would infer a latch).
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        product_d = product_q;
        step_c    = 1'b0;
        step_hs   = acc_hi_q;

        unique case (state_q)
            IDLE, DONE: begin
                // DONE accepts start exactly like IDLE, giving back-to-back ops.
                if (start) begin
                    mcand_d  = a;
                    acc_lo_d = b;
                    acc_hi_d = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end

            RUN: begin
                if (acc_lo_q[0]) begin
                    step_c  = add_cout;
                    step_hs = add_s;
                end
                // Right shift of {carry, upper, lower}; the consumed multiplier
                // bit falls off the bottom of acc_lo.
                {acc_hi_d, acc_lo_d} = {step_c, step_hs, acc_lo_q[WIDTH-1:1]};
                count_d = count_q + 2'd1;
                if (count_q == 2'd3) begin
                    product_d = {acc_hi_d, acc_lo_d};
                    state_d   = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule
